// File: rtl/audio_pair_pkg.sv
// Shared types and helpers for the stereo sample pairer.
package audio_pair_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] left;
        logic [DATA_W_DEFAULT-1:0] right;
    } frame_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a write into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_accept,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             pop;

    always_comb begin
        rd_valid  = (count != '0);
        pop       = rd_valid & rd_ready;
        wr_accept = wr_valid & ((count < LW'(DEPTH)) | pop);
        // Memory is not reset, so the output is forced to zero while empty.
        rd_data   = rd_valid ? mem[rd_ptr] : '0;
        level     = count;
    end

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_accept, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_frame_pairer.sv
// Pairs independently arriving left/right codec samples into stereo frames and buffers them;
// never back-pressures the codec, counting dropped frames and overwritten samples instead.
module audio_frame_pairer
    import audio_pair_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [DATA_W-1:0]          left_in_data,
    input  logic                       left_in_valid,
    output logic                       left_in_ready,
    input  logic [DATA_W-1:0]          right_in_data,
    input  logic                       right_in_valid,
    output logic                       right_in_ready,
    output logic [2*DATA_W-1:0]        frame_data,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           overflow_count,
    output logic [CNT_W-1:0]           skew_count
);

    logic [DATA_W-1:0] l_reg;
    logic [DATA_W-1:0] r_reg;
    logic              l_full;
    logic              r_full;
    logic              in_ready;
    logic              l_acc;
    logic              r_acc;
    logic              pair_fire;
    logic              fifo_accept;
    logic              skew_event;
    logic              overflow_event;

    always_comb begin
        l_acc          = left_in_valid & in_ready;
        r_acc          = right_in_valid & in_ready;
        pair_fire      = l_full & r_full;
        // Both flags set means pair_fire, so at most one channel can skew per cycle.
        skew_event     = ~pair_fire & ((l_acc & l_full) | (r_acc & r_full));
        overflow_event = pair_fire & ~fifo_accept;
    end

    assign left_in_ready  = in_ready;
    assign right_in_ready = in_ready;

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            in_ready <= 1'b0;
        else
            in_ready <= 1'b1;
    end

    always_ff @(posedge clk_clk) begin
        if (l_acc)
            l_reg <= left_in_data;
        if (r_acc)
            r_reg <= right_in_data;
    end

    // A new accept wins over the pair-fire clear so it starts the next pair.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            l_full <= 1'b0;
            r_full <= 1'b0;
        end else begin
            if (l_acc)
                l_full <= 1'b1;
            else if (pair_fire)
                l_full <= 1'b0;
            if (r_acc)
                r_full <= 1'b1;
            else if (pair_fire)
                r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            overflow_count <= '0;
            skew_count     <= '0;
        end else begin
            if (overflow_event)
                overflow_count <= CNT_W'(sat_inc(64'(overflow_count), CNT_W));
            if (skew_event)
                skew_count <= CNT_W'(sat_inc(64'(skew_count), CNT_W));
        end
    end

    sync_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .wr_valid  (pair_fire),
        .wr_data   ({l_reg, r_reg}),
        .wr_accept (fifo_accept),
        .rd_data   (frame_data),
        .rd_valid  (frame_valid),
        .rd_ready  (frame_ready),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_audio_frame_pairer.sv
// Directed self-checking bench for audio_frame_pairer with hand-computed expectations.
module tb_audio_frame_pairer;
    import audio_pair_pkg::*;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [15:0] left_in_data;
    logic        left_in_valid;
    logic        left_in_ready;
    logic [15:0] right_in_data;
    logic        right_in_valid;
    logic        right_in_ready;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [4:0]  fifo_level;
    logic [15:0] overflow_count;
    logic [15:0] skew_count;

    int checks = 0;
    int errors = 0;

    audio_frame_pairer #(
        .DATA_W (16),
        .DEPTH  (16),
        .CNT_W  (16)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .left_in_data   (left_in_data),
        .left_in_valid  (left_in_valid),
        .left_in_ready  (left_in_ready),
        .right_in_data  (right_in_data),
        .right_in_valid (right_in_valid),
        .right_in_ready (right_in_ready),
        .frame_data     (frame_data),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count),
        .skew_count     (skew_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
        frame_t f;
        f.left  = l;
        f.right = r;
        return f;
    endfunction

    initial begin
        reset_reset    = 1'b1;
        left_in_data   = '0;
        left_in_valid  = 1'b0;
        right_in_data  = '0;
        right_in_valid = 1'b0;
        frame_ready    = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_lready", 32'(left_in_ready), 32'd0);
            check("rst_rready", 32'(right_in_ready), 32'd0);
            check("rst_fvalid", 32'(frame_valid), 32'd0);
            check("rst_fdata", frame_data, 32'd0);
            check("rst_level", 32'(fifo_level), 32'd0);
            check("rst_ovf", 32'(overflow_count), 32'd0);
            check("rst_skew", 32'(skew_count), 32'd0);
        end
        reset_reset = 1'b0;
        step();
        check("ready_after_rst_l", 32'(left_in_ready), 32'd1);
        check("ready_after_rst_r", 32'(right_in_ready), 32'd1);

        // Alternating L then R, downstream ready
        frame_ready   = 1'b1;
        left_in_data  = 16'h1234;
        left_in_valid = 1'b1;
        step();
        left_in_valid  = 1'b0;
        right_in_data  = 16'hABCD;
        right_in_valid = 1'b1;
        step();
        right_in_valid = 1'b0;
        check("lat_valid_n1", 32'(frame_valid), 32'd0);
        step();
        check("lat_valid_n2", 32'(frame_valid), 32'd1);
        check("lat_data", frame_data, 32'h1234ABCD);
        check("lat_level", 32'(fifo_level), 32'd1);
        step();
        check("pop_last_valid", 32'(frame_valid), 32'd0);
        check("pop_last_level", 32'(fifo_level), 32'd0);
        check("alt_ovf", 32'(overflow_count), 32'd0);
        check("alt_skew", 32'(skew_count), 32'd0);

        // Same-edge L and R
        left_in_data   = 16'h5555;
        right_in_data  = 16'h6666;
        left_in_valid  = 1'b1;
        right_in_valid = 1'b1;
        step();
        left_in_valid  = 1'b0;
        right_in_valid = 1'b0;
        check("same_valid_n1", 32'(frame_valid), 32'd0);
        step();
        check("same_valid_n2", 32'(frame_valid), 32'd1);
        check("same_data", frame_data, 32'h55556666);
        step();
        check("same_drained", 32'(frame_valid), 32'd0);

        // Skew: two left samples before any right
        left_in_valid = 1'b1;
        left_in_data  = 16'h0001;
        step();
        left_in_data  = 16'h0002;
        step();
        left_in_valid = 1'b0;
        check("skew_count", 32'(skew_count), 32'd1);
        right_in_data  = 16'h0003;
        right_in_valid = 1'b1;
        step();
        right_in_valid = 1'b0;
        step();
        check("skew_frame", frame_data, 32'h00020003);
        check("skew_fvalid", 32'(frame_valid), 32'd1);
        step();
        check("skew_drained", 32'(frame_valid), 32'd0);

        // Overflow: 18 back-to-back pairs with downstream stalled
        frame_ready    = 1'b0;
        left_in_valid  = 1'b1;
        right_in_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            left_in_data  = 16'(i);
            right_in_data = 16'(i + 32'h100);
            step();
        end
        left_in_valid  = 1'b0;
        right_in_valid = 1'b0;
        step();
        check("ovf_level", 32'(fifo_level), 32'd16);
        check("ovf_count", 32'(overflow_count), 32'd2);
        check("ovf_skew_kept", 32'(skew_count), 32'd1);

        // Full FIFO with simultaneous pop and new pair
        left_in_data   = 16'hAAAA;
        right_in_data  = 16'hBBBB;
        left_in_valid  = 1'b1;
        right_in_valid = 1'b1;
        step();
        left_in_valid  = 1'b0;
        right_in_valid = 1'b0;
        frame_ready    = 1'b1;
        check("full_head", frame_data, mk_frame(16'h0000, 16'h0100));
        step();
        check("full_pp_level", 32'(fifo_level), 32'd16);
        check("full_pp_ovf", 32'(overflow_count), 32'd2);

        // Drain: frames 1..15 then the tail frame
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), frame_data, mk_frame(16'(i), 16'(i + 32'h100)));
            step();
        end
        check("drain_tail", frame_data, 32'hAAAABBBB);
        step();
        check("drain_empty_valid", 32'(frame_valid), 32'd0);
        check("drain_empty_level", 32'(fifo_level), 32'd0);

        // Mid-operation reset with level 5 and a pending left sample
        frame_ready    = 1'b0;
        left_in_valid  = 1'b1;
        right_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            left_in_data  = 16'(i + 32'h10);
            right_in_data = 16'(i + 32'h20);
            step();
        end
        right_in_valid = 1'b0;
        left_in_data   = 16'h7777;
        step();
        left_in_valid = 1'b0;
        check("pre_rst_level", 32'(fifo_level), 32'd5);
        reset_reset = 1'b1;
        step();
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_fvalid", 32'(frame_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow_count), 32'd0);
        check("mid_rst_skew", 32'(skew_count), 32'd0);
        check("mid_rst_ready", 32'(left_in_ready), 32'd0);
        reset_reset = 1'b0;
        step();
        check("post_rst_ready", 32'(right_in_ready), 32'd1);
        right_in_data  = 16'h4242;
        right_in_valid = 1'b1;
        step();
        right_in_valid = 1'b0;
        step();
        step();
        check("r_only_fvalid", 32'(frame_valid), 32'd0);
        check("r_only_level", 32'(fifo_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_frame_pairer.md
# audio_frame_pairer

Downstream consumer of the audio codec core's left/right Avalon-ST sample outputs. Captures independently arriving 16-bit left and right samples, pairs them into one 32-bit stereo frame, and buffers frames in a small synchronous FIFO for the mic-array processing chain. Never back-pressures the codec: samples are always accepted after reset, and loss is counted rather than stalled.

## Interface
Parameters:
- DATA_W, 16, sample width per channel
- DEPTH, 16, FIFO depth in frames; power of two, ≥ 2
- CNT_W, 16, width of the saturating error counters

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge
- reset_reset  in  1  synchronous, active-high reset
- left_in_data  in  DATA_W  left sample from the codec core
- left_in_valid  in  1  left sample valid
- left_in_ready  out  1  left accept
- right_in_data  in  DATA_W  right sample
- right_in_valid  in  1  right sample valid
- right_in_ready  out  1  right accept
- frame_data  out  2*DATA_W  {left, right}; left in the MSBs
- frame_valid  out  1  FIFO non-empty
- frame_ready  in  1  downstream accept
- fifo_level  out  $clog2(DEPTH)+1  frames stored
- overflow_count  out  CNT_W  frames dropped because the FIFO was full
- skew_count  out  CNT_W  samples overwritten before being paired

## Operation
- Clock is clk_clk. Reset is synchronous and active-high on reset_reset.
- left_in_ready/right_in_ready are registered: 0 while in reset, 1 from the first cycle after reset deasserts.
- Holding registers L_reg and R_reg, each with a full flag (l_full, r_full).
- pair_fire = l_full & r_full. While pair_fire is high, {L_reg, R_reg} is offered to the FIFO and both flags clear at the next edge.
- Sample accept (valid & ready): load the channel register and set its flag. This applies even when the flag is clearing on the same edge due to pair_fire, so the new sample starts the next pair.
- Skew: accept on a channel whose flag is set while pair_fire is low. The register is overwritten, the flag stays set, and skew_count increments.
- FIFO write on pair_fire when (count < DEPTH) or (frame_valid & frame_ready) in the same cycle. Otherwise the frame is dropped, overflow_count increments, and both flags still clear.
- FIFO is show-ahead:
  - frame_data = mem[rd_ptr]
  - frame_valid = (count != 0)
  - pop on frame_valid & frame_ready
- Pointers wrap modulo DEPTH.
- fifo_level = count, where count = count + push − pop.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- Reset mid-operation: the FIFO, both flags, and both counters clear. In-flight samples are discarded.

## Timing
- Reset values:
  - left_in_ready 0, right_in_ready 0
  - frame_valid 0, frame_data 0, fifo_level 0
  - overflow_count 0, skew_count 0
- Latency, FIFO empty: second sample of a pair accepted at edge N → pair_fire high in cycle N+1 → written at edge N+1 → frame_valid high in cycle N+2.
- Left and right accepted on the same edge: identical latency (frame_valid two cycles later).
- Push and pop in the same cycle: legal when full. count is unchanged and no overflow is recorded.
- Pop of the last frame with no push: frame_valid low on the following cycle.
- fifo_level and both counters are registered and update one edge after the causing event.

## Structure
- Package audio_pair_pkg:
  - DATA_W default
  - frame struct {left, right}
  - saturating-increment function used by both counters
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holds memory, pointers, count and show-ahead output.
- The top level holds the holding registers, ready generation, pairing/skew logic and counters.

## Test plan
- Reset held 3 cycles, then released: all outputs 0 during reset. Ready goes to 1 on cycle 1 after release.
- Alternating L=0x1234 then R=0xABCD, frame_ready=1: frame_data=0x1234ABCD, frame_valid 2 cycles after the R accept, then low again; counters stay 0.
- Two L samples (0x0001, then 0x0002) before any R, then R=0x0003: skew_count=1, frame=0x00020003.
- frame_ready=0, 18 pairs with DEPTH=16: fifo_level=16, overflow_count=2. Draining yields the first 16 frames in order.
- FIFO full, frame_ready=1 while a new pair fires: fifo_level stays 16, overflow_count unchanged, new frame appears at the tail.
- Reset asserted with FIFO at level 5 and l_full set: next cycle level 0, frame_valid 0, counts 0. A following R-only sample produces no frame.
